// File: rtl/reg_stack_pkg.sv
// Shared definitions for the register/stack sequencer: opcodes, FSM states,
// error-flag bit positions and the decoded strobe set.
package reg_stack_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDI   = 4'd1;
  localparam logic [3:0] OP_SETB  = 4'd2;
  localparam logic [3:0] OP_PUSH  = 4'd3;
  localparam logic [3:0] OP_PUSHI = 4'd4;
  localparam logic [3:0] OP_POP   = 4'd5;
  localparam logic [3:0] OP_LDM   = 4'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    POP_WB = 2'd2
  } state_t;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UDF = 1;

  // One bit per strobe driven towards the register file / stack block.
  typedef struct packed {
    logic we;
    logic set_bit;
    logic fifo_en;
    logic push_reg;
    logic fifo_rd;
    logic fifo_wr;
    logic mem_en;
  } strobe_t;

  localparam strobe_t STROBE_NONE = '0;

endpackage

// File: rtl/reg_stack_decode.sv
// Combinational opcode-to-strobe decoder; opcodes 7..15 decode as NOP.
module reg_stack_decode
  import reg_stack_pkg::*;
(
  input  logic [3:0] i_opcode,
  output strobe_t    o_strobe
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
    o_strobe = STROBE_NONE;
    case (i_opcode)
      OP_LDI: begin
        o_strobe.we = 1'b1;
      end
      OP_SETB: begin
        o_strobe.we      = 1'b1;
        o_strobe.set_bit = 1'b1;
      end
      OP_PUSH: begin
        o_strobe.push_reg = 1'b1;
        o_strobe.fifo_wr  = 1'b1;
      end
      OP_PUSHI: begin
        o_strobe.fifo_wr = 1'b1;
      end
      OP_POP: begin
        o_strobe.fifo_rd = 1'b1;
      end
      OP_LDM: begin
        o_strobe.we      = 1'b1;
        o_strobe.fifo_en = 1'b1;
        o_strobe.mem_en  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/reg_stack_sequencer.sv
// Instruction sequencer feeding the register file / stack block.
// Define REG_STACK_SEQ_GUARD_EN to enable full/empty guards and STACK_Error.
module reg_stack_sequencer
  import reg_stack_pkg::*;
#(
  parameter int FetchBits  = 8,
  parameter int MemorySize = 2
) (
  input  logic                 CLK,
  input  logic                 CPU_Reset_n,
  input  logic                 INSTR_Valid,
  output logic                 INSTR_Ready,
  input  logic [3:0]           INSTR_Opcode,
  input  logic [3:0]           INSTR_Addr,
  input  logic [FetchBits-1:0] INSTR_Imm,
  input  logic                 FIFO_EmptySignal,
  input  logic                 FIFO_FullSignal,
  input  logic                 ERR_Clear,
  output logic                 REGISTERS_WE,
  output logic                 REGISTERS_SetBitData,
  output logic [3:0]           REGISTERS_ADDR,
  output logic                 REGISTERS_BitData,
  output logic [FetchBits-1:0] REGISTERS_WordData,
  output logic                 FIFO_EN,
  output logic                 FIFO_PUSH_REG,
  output logic                 FIFO_RD,
  output logic                 FIFO_WR,
  output logic                 FIFO_Memory_EN,
  output logic                 FIFO_Memory_WR,
  output logic [1:0]           STACK_Error,
  output logic                 BUSY
);

  if (FetchBits != 8 || MemorySize < 1 || MemorySize > 4) begin : g_bad_param
    $error("reg_stack_sequencer: FetchBits must be 8 and MemorySize 1..4");
  end

  state_t               r_state;
  state_t               w_next;
  strobe_t              w_dec;
  strobe_t              w_strobe_d;
  strobe_t              r_strobe;
  logic [3:0]           r_addr;
  logic [FetchBits-1:0] r_word;
  logic                 r_bit;
  logic                 w_accept;
  logic                 w_exec;
  logic                 w_block_wr;
  logic                 w_block_rd;
  logic                 w_pop_go;

  reg_stack_decode u_decode (
    .i_opcode (INSTR_Opcode),
    .o_strobe (w_dec)
  );

  assign w_accept = INSTR_Valid && (r_state == IDLE);
  assign w_exec   = (r_state == EXEC);

`ifdef REG_STACK_SEQ_GUARD_EN
  // Flags are judged while the strobe is on the wire, so a blocked strobe never leaves the block.
  assign w_block_wr = w_exec && r_strobe.fifo_wr && FIFO_FullSignal;
  assign w_block_rd = w_exec && r_strobe.fifo_rd && FIFO_EmptySignal;
`else
  logic w_unused_guard_inputs;
  assign w_unused_guard_inputs = ^{FIFO_FullSignal, FIFO_EmptySignal, ERR_Clear};
  assign w_block_wr = 1'b0;
  assign w_block_rd = 1'b0;
`endif

  assign w_pop_go = w_exec && r_strobe.fifo_rd && !w_block_rd;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = w_pop_go ? POP_WB : IDLE;
      POP_WB:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_strobe_d = STROBE_NONE;
    if (w_accept) begin
      w_strobe_d = w_dec;
    end else if (w_pop_go) begin
      w_strobe_d.we      = 1'b1;
      w_strobe_d.fifo_en = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      r_state  <= IDLE;
      r_strobe <= STROBE_NONE;
    end else begin
      r_state  <= w_next;
      r_strobe <= w_strobe_d;
    end
  end

  // Address and data registers are reset too, because every output must read 0 in reset.
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      r_addr <= '0;
      r_word <= '0;
      r_bit  <= 1'b0;
    end else if (w_accept) begin
      r_addr <= INSTR_Addr;
      r_word <= INSTR_Imm;
      r_bit  <= INSTR_Imm[0];
    end
  end

`ifdef REG_STACK_SEQ_GUARD_EN
  logic [1:0] r_err;
  logic [1:0] w_err_set;

  assign w_err_set[ERR_OVF] = w_block_wr;
  assign w_err_set[ERR_UDF] = w_block_rd;

  // A new error in the clearing cycle survives the clear.
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      r_err <= 2'b00;
    end else begin
      r_err <= (ERR_Clear ? 2'b00 : r_err) | w_err_set;
    end
  end

  assign STACK_Error = r_err;
`else
  assign STACK_Error = 2'b00;
`endif

  assign INSTR_Ready          = (r_state == IDLE);
  assign BUSY                 = (r_state != IDLE);
  assign REGISTERS_WE         = r_strobe.we;
  assign REGISTERS_SetBitData = r_strobe.set_bit;
  assign REGISTERS_ADDR       = r_addr;
  assign REGISTERS_BitData    = r_bit;
  assign REGISTERS_WordData   = r_word;
  assign FIFO_EN              = r_strobe.fifo_en;
  assign FIFO_PUSH_REG        = r_strobe.push_reg;
  assign FIFO_RD              = r_strobe.fifo_rd && !w_block_rd;
  assign FIFO_WR              = r_strobe.fifo_wr && !w_block_wr;
  assign FIFO_Memory_EN       = r_strobe.mem_en;
  assign FIFO_Memory_WR       = 1'b0;

endmodule

// File: tb/tb_reg_stack_sequencer.sv
// Self-checking bench for reg_stack_sequencer: directed steps plus random
// instructions, checked against a per-instruction reference model.
module tb_reg_stack_sequencer;

`ifdef REG_STACK_SEQ_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       CPU_Reset_n;
  logic       INSTR_Valid;
  logic       INSTR_Ready;
  logic [3:0] INSTR_Opcode;
  logic [3:0] INSTR_Addr;
  logic [7:0] INSTR_Imm;
  logic       FIFO_EmptySignal;
  logic       FIFO_FullSignal;
  logic       ERR_Clear;
  logic       REGISTERS_WE;
  logic       REGISTERS_SetBitData;
  logic [3:0] REGISTERS_ADDR;
  logic       REGISTERS_BitData;
  logic [7:0] REGISTERS_WordData;
  logic       FIFO_EN;
  logic       FIFO_PUSH_REG;
  logic       FIFO_RD;
  logic       FIFO_WR;
  logic       FIFO_Memory_EN;
  logic       FIFO_Memory_WR;
  logic [1:0] STACK_Error;
  logic       BUSY;

  reg_stack_sequencer #(.FetchBits(8), .MemorySize(2)) dut (
    .CLK                  (CLK),
    .CPU_Reset_n          (CPU_Reset_n),
    .INSTR_Valid          (INSTR_Valid),
    .INSTR_Ready          (INSTR_Ready),
    .INSTR_Opcode         (INSTR_Opcode),
    .INSTR_Addr           (INSTR_Addr),
    .INSTR_Imm            (INSTR_Imm),
    .FIFO_EmptySignal     (FIFO_EmptySignal),
    .FIFO_FullSignal      (FIFO_FullSignal),
    .ERR_Clear            (ERR_Clear),
    .REGISTERS_WE         (REGISTERS_WE),
    .REGISTERS_SetBitData (REGISTERS_SetBitData),
    .REGISTERS_ADDR       (REGISTERS_ADDR),
    .REGISTERS_BitData    (REGISTERS_BitData),
    .REGISTERS_WordData   (REGISTERS_WordData),
    .FIFO_EN              (FIFO_EN),
    .FIFO_PUSH_REG        (FIFO_PUSH_REG),
    .FIFO_RD              (FIFO_RD),
    .FIFO_WR              (FIFO_WR),
    .FIFO_Memory_EN       (FIFO_Memory_EN),
    .FIFO_Memory_WR       (FIFO_Memory_WR),
    .STACK_Error          (STACK_Error),
    .BUSY                 (BUSY)
  );

  always #5 CLK = ~CLK;

  // Observed control vector: {WE, SetBit, FIFO_EN, PUSH_REG, RD, WR, MEM_EN, MEM_WR, BUSY, READY}
  wire [9:0] w_obs = {REGISTERS_WE, REGISTERS_SetBitData, FIFO_EN, FIFO_PUSH_REG, FIFO_RD,
                      FIFO_WR, FIFO_Memory_EN, FIFO_Memory_WR, BUSY, INSTR_Ready};

  localparam logic [9:0] V_IDLE   = 10'b00000000_0_1;
  localparam logic [9:0] V_POP_WB = 10'b10100000_1_0;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] m_err   = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected vector in the cycle after acceptance, straight from the opcode table.
  function automatic logic [9:0] exp_exec(input logic [3:0] op, input logic full, input logic empty);
    logic we = 0, sb = 0, fe = 0, pr = 0, rd = 0, wr = 0, me = 0;
    case (op)
      4'd1: we = 1;
      4'd2: begin we = 1; sb = 1; end
      4'd3: begin pr = 1; wr = !(GUARD && full); end
      4'd4: wr = !(GUARD && full);
      4'd5: rd = !(GUARD && empty);
      4'd6: begin we = 1; fe = 1; me = 1; end
      default: ;
    endcase
    return {we, sb, fe, pr, rd, wr, me, 1'b0, 1'b1, 1'b0};
  endfunction

  // Issue one instruction from an idle negedge and check every cycle until idle again.
  task automatic issue(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] imm,
                       input logic full, input logic empty, input logic clr);
    logic [1:0] new_err;
    bit         has_wb;
    check("ready_before_accept", INSTR_Ready, 1'b1);
    INSTR_Valid = 1; INSTR_Opcode = op; INSTR_Addr = addr; INSTR_Imm = imm;
    FIFO_FullSignal = full; FIFO_EmptySignal = empty;
    @(negedge CLK);
    INSTR_Valid = 0; ERR_Clear = clr;
    check($sformatf("exec_op%0d", op), w_obs, exp_exec(op, full, empty));
    check("exec_addr", REGISTERS_ADDR, addr);
    if (op == 4'd1 || op == 4'd4) check("exec_word", REGISTERS_WordData, imm);
    if (op == 4'd2) check("exec_bit", REGISTERS_BitData, imm[0]);
    new_err = {GUARD && op == 4'd5 && empty, GUARD && (op == 4'd3 || op == 4'd4) && full};
    m_err   = (clr ? 2'b00 : m_err) | new_err;
    has_wb  = (op == 4'd5) && !(GUARD && empty);
    @(negedge CLK);
    ERR_Clear = 0;
    check("stack_error", STACK_Error, m_err);
    if (has_wb) begin
      check("pop_wb", w_obs, V_POP_WB);
      check("pop_wb_addr", REGISTERS_ADDR, addr);
      @(negedge CLK);
    end
    check("back_to_idle", w_obs, V_IDLE);
  endtask

  task automatic clear_err();
    ERR_Clear = 1;
    @(negedge CLK);
    ERR_Clear = 0;
    m_err = 2'b00;
    check("err_cleared", STACK_Error, m_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    CPU_Reset_n = 0; INSTR_Valid = 0; INSTR_Opcode = 0; INSTR_Addr = 0; INSTR_Imm = 0;
    FIFO_EmptySignal = 0; FIFO_FullSignal = 0; ERR_Clear = 0;
    repeat (2) @(negedge CLK);
    check("reset_vec", w_obs, V_IDLE);
    check("reset_addr", REGISTERS_ADDR, 4'h0);
    check("reset_word", REGISTERS_WordData, 8'h00);
    check("reset_err", STACK_Error, 2'b00);
    CPU_Reset_n = 1;
    @(negedge CLK);

    issue(4'd1, 4'd2, 8'hA5, 0, 0, 0);   // LDI R2, 0xA5
    issue(4'd2, 4'd1, 8'h01, 0, 0, 0);   // SETB R1, 1
    issue(4'd4, 4'd0, 8'h3C, 0, 0, 0);   // PUSHI 0x3C
    issue(4'd5, 4'd3, 8'h00, 0, 0, 0);   // POP R3
    issue(4'd6, 4'd2, 8'h00, 0, 0, 0);   // LDM R2
    issue(4'd0, 4'd1, 8'hFF, 0, 0, 0);   // NOP
    issue(4'd9, 4'd2, 8'h11, 1, 1, 0);   // undefined opcode behaves as NOP
    issue(4'd3, 4'd1, 8'h00, 1, 0, 0);   // PUSH while full
    issue(4'd5, 4'd2, 8'h00, 0, 1, 0);   // POP while empty
    clear_err();
    issue(4'd5, 4'd0, 8'h00, 0, 1, 0);   // underflow again
    issue(4'd4, 4'd0, 8'h5A, 1, 0, 1);   // overflow in the clearing cycle wins
    clear_err();

    // Valid held high across a POP: the next instruction waits for INSTR_Ready.
    check("hold_ready", INSTR_Ready, 1'b1);
    INSTR_Valid = 1; INSTR_Opcode = 4'd5; INSTR_Addr = 4'd1; INSTR_Imm = 8'h00;
    FIFO_FullSignal = 0; FIFO_EmptySignal = 0;
    @(negedge CLK);
    INSTR_Opcode = 4'd1; INSTR_Addr = 4'd2; INSTR_Imm = 8'h77;
    check("hold_exec", w_obs, exp_exec(4'd5, 0, 0));
    @(negedge CLK);
    check("hold_pop_wb", w_obs, V_POP_WB);
    check("hold_pop_wb_addr", REGISTERS_ADDR, 4'd1);
    @(negedge CLK);
    check("hold_idle", w_obs, V_IDLE);
    @(negedge CLK);
    INSTR_Valid = 0;
    check("hold_ldi_exec", w_obs, exp_exec(4'd1, 0, 0));
    check("hold_ldi_addr", REGISTERS_ADDR, 4'd2);
    check("hold_ldi_word", REGISTERS_WordData, 8'h77);
    @(negedge CLK);
    check("hold_done", w_obs, V_IDLE);

    // Reset asserted during POP_WB abandons the writeback.
    INSTR_Valid = 1; INSTR_Opcode = 4'd5; INSTR_Addr = 4'd3; FIFO_EmptySignal = 0;
    @(negedge CLK);
    INSTR_Valid = 0;
    check("rst_pop_exec", w_obs, exp_exec(4'd5, 0, 0));
    @(posedge CLK);
    #1 CPU_Reset_n = 0;
    #1;
    check("rst_pop_we", REGISTERS_WE, 1'b0);
    check("rst_pop_vec", w_obs, V_IDLE);
    @(negedge CLK);
    CPU_Reset_n = 1;
    m_err = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_pop_quiet", w_obs, V_IDLE);
    end
    check("rst_pop_err", STACK_Error, m_err);

    // Random instruction stream.
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      issue(op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK);
        check("rand_gap_idle", w_obs, V_IDLE);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
